// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, SLL/SRL/SRA/ROR.
// Rotate support is built only when SHIFT_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module barrel_shifter_pipe #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  logic [WIDTH-1:0] data_q [SHW];
  logic [SHW-1:0]   amt_q  [SHW];
  logic [1:0]       op_q   [SHW];
  logic             sign_q [SHW];
  logic             vld_q  [SHW];
  logic             en;

  // Shift by a fixed power-of-two distance s; sign is the operand's original MSB.
  function automatic logic [WIDTH-1:0] stage_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       op,
                                                   input logic             sign,
                                                   input int unsigned      s);
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] res;
    fill = ~({WIDTH{1'b1}} >> s);
    res  = d >> s;
    case (op)
      2'b00:   res = d << s;
      2'b01:   res = d >> s;
      2'b10:   res = (d >> s) | (sign ? fill : '0);
      default: begin
`ifdef SHIFT_ROTATE_EN
        res = (d >> s) | (d << (WIDTH - s));
`else
        res = d >> s;
`endif
      end
    endcase
    return res;
  endfunction

  // A single global enable: the whole pipe advances or holds together.
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SHW; k++) begin
        vld_q[k]  <= 1'b0;
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        op_q[k]   <= '0;
        sign_q[k] <= 1'b0;
      end
    end else if (en) begin
      // stage 0: take the operand straight from the input port
      vld_q[0]  <= in_valid;
      data_q[0] <= in_amt[0] ? stage_shift(in_data, in_op, in_data[WIDTH-1], 1) : in_data;
      amt_q[0]  <= in_amt;
      op_q[0]   <= in_op;
      sign_q[0] <= in_data[WIDTH-1];
      // stages 1..SHW-1: each consumes one more amount bit
      for (int k = 1; k < SHW; k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= amt_q[k-1][k] ? stage_shift(data_q[k-1], op_q[k-1], sign_q[k-1], 1 << k)
                                   : data_q[k-1];
        amt_q[k]  <= amt_q[k-1];
        op_q[k]   <= op_q[k-1];
        sign_q[k] <= sign_q[k-1];
      end
    end
  end

  assign out_valid = vld_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_zero  = out_valid & ~|data_q[SHW-1];

endmodule

// File: doc/barrel_shifter_pipe.md
BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, data width in bits; SHALL be a power of two, 8 to 64.
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width; derived, not overridden.
REQ-003 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_n  in  1  synchronous, active-low reset, sampled on rising clock.
REQ-005 Port: in_valid  in  1  input operand valid.
REQ-006 Port: in_ready  out  1  block accepts an operand this cycle.
REQ-007 Port: in_data  in  WIDTH  operand.
REQ-008 Port: in_amt  in  SHW  shift amount, 0 to WIDTH-1.
REQ-009 Port: in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port: out_valid  out  1  result valid.
REQ-011 Port: out_ready  in  1  downstream accepts the result.
REQ-012 Port: out_data  out  WIDTH  shifted result.
REQ-013 Port: out_zero  out  1  high when out_data is all zero; qualified by out_valid.

Function
REQ-014 SHALL be a pipeline of SHW register stages; stage k conditionally shifts by 2^k when amount bit k is set.
REQ-015 Each stage SHALL register the data, remaining amount bits, op, original sign bit and a valid bit.
REQ-016 Transfer in SHALL occur when in_valid and in_ready are both high; transfer out SHALL occur when out_valid and out_ready are both high.
REQ-017 Global advance enable SHALL be en = out_ready | ~out_valid; all stages SHALL load on en and hold otherwise.
REQ-018 in_ready SHALL equal en (combinational); bubbles are not collapsed.
REQ-019 Latency SHALL be exactly SHW cycles from input transfer to out_valid when en stays high; throughput one operation per cycle.
REQ-020 SLL SHALL fill vacated LSBs with 0; SRL SHALL fill MSBs with 0; SRA SHALL fill MSBs with in_data[WIDTH-1].
REQ-021 ROR SHALL rotate right, bits leaving bit 0 entering bit WIDTH-1.
REQ-022 in_amt = 0 SHALL yield out_data = in_data for every op.
REQ-023 While stalled (out_valid high, out_ready low), out_data, out_zero and out_valid SHALL remain stable.
REQ-024 Results SHALL emerge in input order; none SHALL be dropped or duplicated.
REQ-025 in_data, in_amt and in_op SHALL be ignored in cycles with no input transfer; the stage-0 valid bit SHALL then load 0 on en.
REQ-026 out_zero SHALL be computed from the final-stage data register, not a separate pipeline.

Reset
REQ-027 With reset_n low at a rising edge, all stage valid bits SHALL clear, out_valid = 0, out_data = 0, out_zero = 0 the next cycle.
REQ-028 Reset mid-operation SHALL discard all in-flight operations; none SHALL be emitted afterward.
REQ-029 in_ready SHALL be high during and after reset, since out_valid = 0.
REQ-030 An input presented in the reset cycle SHALL NOT be accepted.

Configuration
REQ-031 Macro SHIFT_ROTATE_EN: when defined, op 11 SHALL perform ROR per REQ-021.
REQ-032 When SHIFT_ROTATE_EN is undefined, op 11 SHALL behave exactly as SRL and no rotate wrap logic SHALL be synthesised.

Verification
REQ-033 WIDTH=32, SLL, in_data=0x00000001, in_amt=31, out_ready=1 -> out_data=0x80000000 exactly 5 cycles later, out_zero=0.
REQ-034 SRA, in_data=0x80000000, in_amt=4 -> 0xF8000000; SRL same operands -> 0x08000000; SLL 0x80000000 amt 1 -> 0x00000000, out_zero=1.
REQ-035 op=11, in_data=0x00000001, in_amt=1 -> 0x80000000 with SHIFT_ROTATE_EN; 0x00000000 with out_zero=1 without it.
REQ-036 Stream 8 ops back-to-back, drop out_ready for 3 cycles mid-stream -> in_ready low while stalled, out_data stable, all 8 results in order, no loss.
REQ-037 Three ops in flight, reset_n low one cycle -> out_valid=0 next cycle, no result from those ops ever appears, a new op after reset emerges with 5-cycle latency.
REQ-038 Any op with in_amt=0 and in_data=0xA5A5A5A5 -> out_data=0xA5A5A5A5.
